register_file_write_arbiter: RTL and testbench
==============================================

// Module: register_file_write_arbiter
// PURPOSE
//  Sequences and shares the single write port of the 4x4 register file.
//  Two requesters (A, B) compete for the port through a req/ack handshake,
//  with round-robin fairness. After reset, or on an init pulse, a sweep
//  sequencer writes SWEEP_VAL to every address before any requester is served.
//  Sits between the client logic and register_file_4x4's write/wr_address/in pins.
// PARAMETERS
//  DATA_W     4    data width of the register file
//  ADDR_W     2    write-address width; DEPTH = 2**ADDR_W entries
//  SWEEP_VAL  0    value written to every entry during a sweep (DATA_W bits)
// PORTS
//  clk            in   1       system clock; all state changes on rising edge
//  clr_n          in   1       asynchronous, active-low reset
//  init           in   1       1-cycle pulse: start or restart a sweep
//  a_req          in   1       requester A wants a write; held until a_ack
//  a_addr         in   ADDR_W  requester A target address
//  a_data         in   DATA_W  requester A write data
//  a_ack          out  1       1-cycle pulse: A's write has been issued
//  b_req/b_addr/b_data/b_ack   same as A, for requester B
//  rf_write       out  1       register-file write enable
//  rf_wr_address  out  ADDR_W  register-file write address
//  rf_in          out  DATA_W  register-file write data
//  busy           out  1       high while a sweep is in progress
// BEHAVIOUR
//  Reset (clr_n=0, asynchronous): state=SWEEP, cnt=0, rr_ptr=A.
//   Outputs: rf_write=0, rf_wr_address=0, rf_in=0, a_ack=b_ack=0, busy=1.
//  All outputs are registered. Write outputs and ack are valid in the cycle
//   after the deciding edge, so request-to-write latency is 1 cycle.
//  SWEEP: on each edge, drive rf_write=1, rf_wr_address=cnt, rf_in=SWEEP_VAL;
//   then cnt++. The edge that issues cnt=DEPTH-1 moves state to RUN, sets
//   busy=0 and clears cnt. This gives exactly DEPTH consecutive write cycles.
//   Requests are ignored during SWEEP (no ack) and stay pending.
//  RUN: each edge, eligible_x = x_req & ~x_ack (a requester is not re-granted
//   in its own ack cycle).
//   - Neither eligible: rf_write=0. Address and data hold their last value.
//   - One eligible: grant it.
//   - Both eligible: grant the side named by rr_ptr.
//   - Grant x: rf_write=1, rf_wr_address=x_addr, rf_in=x_data, x_ack=1 for
//     one cycle. rr_ptr becomes the other side.
//   - Peak throughput is one write per cycle when alternating A and B; a single
//     requester gets at most one write per 2 cycles.
//  init=1 in RUN: takes priority over requests. No grant that edge.
//   Next edge state=SWEEP, busy=1, rf_write=0, cnt=0; the sweep writes start
//   on the following edge.
//  init=1 in SWEEP: cnt restarts at 0 and the sweep is re-run in full.
//  Reset mid-sweep or mid-grant: everything returns to reset values
//   immediately. No ack is issued for an interrupted grant; a sweep restarts
//   after clr_n is released.
//  Address and data are sampled only on the grant edge; later changes to them
//   do not affect an issued write.
// TESTING
//  1. Release clr_n, no reqs -> rf_write=1 for 4 cycles at addr 0,1,2,3 with
//     rf_in=0; then busy=0 and rf_write=0.
//  2. After the sweep, a_req with addr=2, data=0xA -> next cycle rf_write=1,
//     addr=2, in=0xA, a_ack=1 for exactly 1 cycle.
//  3. a_req and b_req held continuously after reset -> grants alternate
//     A,B,A,B; each ack is 1 cycle and rf_write stays 1 every cycle.
//  4. A request raised during a sweep (cycle 2) -> no ack until the sweep ends;
//     it is granted on the first RUN edge.
//  5. init pulse together with b_req in RUN -> no b_ack; a 4-write sweep of 0
//     runs, then B is granted with its original addr/data.
//  6. clr_n low during sweep cnt=2 -> outputs reset immediately; after release,
//     the full sweep restarts at addr 0.

Source files
------------

// File: rtl/register_file_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the 4x4 register file.
// The master side is the client logic, and the slave side is the arbiter.
interface register_file_write_arbiter_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ack;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ack;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_wr_address;
    logic [DATA_W-1:0] rf_in;
    logic              busy;

    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data,
        input  a_ack, b_ack, rf_write, rf_wr_address, rf_in, busy
    );

    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data,
        output a_ack, b_ack, rf_write, rf_wr_address, rf_in, busy
    );
endinterface

// File: rtl/register_file_write_arbiter.sv
// Shares the register-file write port between requesters A and B using round-robin.
// A SWEEP_VAL fill of every entry runs first, both after reset and after each init pulse.
module register_file_write_arbiter #(
    parameter int unsigned       DATA_W    = 4,
    parameter int unsigned       ADDR_W    = 2,
    parameter logic [DATA_W-1:0] SWEEP_VAL = '0
) (
    input  logic                               clk,
    input  logic                               clr_n,
    input  logic                               init,
    register_file_write_arbiter_if.slave       bus
);
    typedef enum logic {SWEEP, RUN} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rr_b_q;     // 1: B wins the next tie
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              busy_q;

    logic elig_a;
    logic elig_b;
    logic grant_a;
    logic grant_b;

    // A requester whose ack is still showing has already been served.
    always_comb begin
        elig_a  = bus.a_req & ~a_ack_q;
        elig_b  = bus.b_req & ~b_ack_q;
        grant_a = elig_a & (~elig_b | ~rr_b_q);
        grant_b = elig_b & ~grant_a;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            rr_b_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            if (init) begin
                // An init pulse spends one idle edge here, whatever the current state.
                // The fill writes then start on the edge that follows.
                state_q <= SWEEP;
                cnt_q   <= '0;
                write_q <= 1'b0;
                busy_q  <= 1'b1;
            end else if (state_q == SWEEP) begin
                write_q <= 1'b1;
                addr_q  <= cnt_q;
                data_q  <= SWEEP_VAL;
                if (cnt_q == '1) begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (grant_a) begin
                write_q <= 1'b1;
                addr_q  <= bus.a_addr;
                data_q  <= bus.a_data;
                a_ack_q <= 1'b1;
                rr_b_q  <= 1'b1;
            end else if (grant_b) begin
                write_q <= 1'b1;
                addr_q  <= bus.b_addr;
                data_q  <= bus.b_data;
                b_ack_q <= 1'b1;
                rr_b_q  <= 1'b0;
            end else begin
                write_q <= 1'b0;
            end
        end
    end

    assign bus.a_ack         = a_ack_q;
    assign bus.b_ack         = b_ack_q;
    assign bus.rf_write      = write_q;
    assign bus.rf_wr_address = addr_q;
    assign bus.rf_in         = data_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_register_file_write_arbiter.sv
// Bench for register_file_write_arbiter: directed scenarios, then random traffic.
// Every cycle is compared against a behavioural model of the arbiter.
module tb_register_file_write_arbiter;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int          DEPTH  = 4;
    localparam logic [DATA_W-1:0] SWEEP_VAL = 4'h0;

    logic clk = 1'b0;
    logic clr_n;
    logic init;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    register_file_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    register_file_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SWEEP_VAL(SWEEP_VAL)
    ) dut (
        .clk(clk), .clr_n(clr_n), .init(init), .bus(bus.slave)
    );

    // Model state: remaining fill writes, the side that wins the next tie, and the expected outputs.
    bit                m_sweeping;
    int                m_left;
    bit                m_turn_b;
    logic              e_write;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_aack;
    logic              e_back;
    logic              e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sweeping = 1'b1;
        m_left     = DEPTH;
        m_turn_b   = 1'b0;
        e_write = 1'b0; e_addr = '0; e_data = '0;
        e_aack  = 1'b0; e_back = 1'b0; e_busy = 1'b1;
    endtask

    // Work out what the coming rising edge should produce from the inputs presently applied.
    task automatic model_edge();
        bit want_a, want_b, pick_a;
        want_a = bus.a_req && !e_aack;
        want_b = bus.b_req && !e_back;
        e_aack = 1'b0;
        e_back = 1'b0;
        if (init) begin
            m_sweeping = 1'b1;
            m_left     = DEPTH;
            e_write    = 1'b0;
            e_busy     = 1'b1;
        end else if (m_sweeping) begin
            e_write = 1'b1;
            e_addr  = ADDR_W'(DEPTH - m_left);
            e_data  = SWEEP_VAL;
            m_left--;
            if (m_left == 0) begin
                m_sweeping = 1'b0;
                e_busy     = 1'b0;
            end
        end else if (want_a || want_b) begin
            pick_a = want_a && (!want_b || !m_turn_b);
            e_write  = 1'b1;
            e_addr   = pick_a ? bus.a_addr : bus.b_addr;
            e_data   = pick_a ? bus.a_data : bus.b_data;
            e_aack   = pick_a;
            e_back   = !pick_a;
            m_turn_b = pick_a;
        end else begin
            e_write = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".write"}, 32'(bus.rf_write), 32'(e_write));
        chk({tag, ".addr"},  32'(bus.rf_wr_address), 32'(e_addr));
        chk({tag, ".data"},  32'(bus.rf_in), 32'(e_data));
        chk({tag, ".a_ack"}, 32'(bus.a_ack), 32'(e_aack));
        chk({tag, ".b_ack"}, 32'(bus.b_ack), 32'(e_back));
        chk({tag, ".busy"},  32'(bus.busy), 32'(e_busy));
    endtask

    // Call at a falling edge. Returns at the next falling edge once the outputs have been compared.
    task automatic tick(input string tag);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Called at a falling edge. Holds clr_n low for one cycle and releases it at a falling edge.
    task automatic do_reset(input string tag);
        clr_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n = 1'b0; init = 1'b0;
        bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        @(negedge clk);
        do_reset("rst");

        // After reset, the fill writes addresses 0..3 with SWEEP_VAL and then goes idle.
        for (int k = 0; k < DEPTH; k++) begin
            tick("t1");
            chk("t1_addr", 32'(bus.rf_wr_address), 32'(k));
            chk("t1_wr", 32'(bus.rf_write), 32'd1);
        end
        tick("t1_end");
        chk("t1_idle_wr", 32'(bus.rf_write), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd0);

        // A single request is written one cycle later, and its ack lasts exactly one cycle.
        bus.a_req = 1'b1; bus.a_addr = 2'd2; bus.a_data = 4'hA;
        tick("t2");
        chk("t2_ack", 32'(bus.a_ack), 32'd1);
        chk("t2_addr", 32'(bus.rf_wr_address), 32'd2);
        chk("t2_data", 32'(bus.rf_in), 32'hA);
        bus.a_req = 1'b0;
        tick("t2b");
        chk("t2_ack_drop", 32'(bus.a_ack), 32'd0);

        // With both requests held, grants alternate and a write is issued every cycle.
        do_reset("t3rst");
        bus.a_req = 1'b1; bus.a_addr = 2'd1; bus.a_data = 4'h3;
        bus.b_req = 1'b1; bus.b_addr = 2'd3; bus.b_data = 4'hC;
        for (int k = 0; k < DEPTH; k++) tick("t3s");
        for (int k = 0; k < 6; k++) begin
            tick("t3");
            chk("t3_alt_a", 32'(bus.a_ack), 32'((k % 2) == 0));
            chk("t3_alt_b", 32'(bus.b_ack), 32'((k % 2) == 1));
            chk("t3_wr", 32'(bus.rf_write), 32'd1);
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick("t3e");

        // A request raised during the fill waits and is granted on the first edge after it.
        do_reset("t4rst");
        tick("t4s"); tick("t4s");
        bus.a_req = 1'b1; bus.a_addr = 2'd3; bus.a_data = 4'h7;
        tick("t4s"); chk("t4_noack", 32'(bus.a_ack), 32'd0);
        tick("t4s"); chk("t4_noack", 32'(bus.a_ack), 32'd0);
        tick("t4g"); chk("t4_ack", 32'(bus.a_ack), 32'd1);
        chk("t4_addr", 32'(bus.rf_wr_address), 32'd3);
        bus.a_req = 1'b0;
        tick("t4e");

        // init wins over a pending B request. B is served only after the new fill completes.
        init = 1'b1;
        bus.b_req = 1'b1; bus.b_addr = 2'd1; bus.b_data = 4'h5;
        tick("t5i");
        chk("t5_noack", 32'(bus.b_ack), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd1);
        chk("t5_nowr", 32'(bus.rf_write), 32'd0);
        init = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick("t5s");
            chk("t5_saddr", 32'(bus.rf_wr_address), 32'(k));
            chk("t5_sdata", 32'(bus.rf_in), 32'(SWEEP_VAL));
        end
        tick("t5g");
        chk("t5_back", 32'(bus.b_ack), 32'd1);
        chk("t5_addr", 32'(bus.rf_wr_address), 32'd1);
        chk("t5_data", 32'(bus.rf_in), 32'h5);
        bus.b_req = 1'b0;
        tick("t5e");

        // Asserting reset part-way through the fill clears outputs at once, and the fill then restarts from address 0.
        do_reset("t6rst");
        tick("t6s"); tick("t6s");
        do_reset("t6mid");
        chk("t6_imm_wr", 32'(bus.rf_write), 32'd0);
        tick("t6r");
        chk("t6_addr0", 32'(bus.rf_wr_address), 32'd0);
        chk("t6_wr", 32'(bus.rf_write), 32'd1);

        // Random traffic: requesters keep req and payload stable until their ack arrives.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (e_aack) bus.a_req = 1'b0;
            if (e_back) bus.b_req = 1'b0;
            if (!bus.a_req && $urandom_range(1, 0) == 1) begin
                bus.a_req  = 1'b1;
                bus.a_addr = ADDR_W'($urandom);
                bus.a_data = DATA_W'($urandom);
            end
            if (!bus.b_req && $urandom_range(1, 0) == 1) begin
                bus.b_req  = 1'b1;
                bus.b_addr = ADDR_W'($urandom);
                bus.b_data = DATA_W'($urandom);
            end
            init = ($urandom_range(39, 0) == 0);
            if ($urandom_range(299, 0) == 0) begin
                init = 1'b0;
                do_reset("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
